pll_phase_step_ctrl: RTL and testbench



---
 rtl/pll_phase_pkg.sv | 32 +++
 rtl/pll_phase_step_ctrl_if.sv | 24 ++
 rtl/pll_phase_step_ctrl_lock_sync2.sv | 20 ++
 rtl/pll_phase_step_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pll_phase_step_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_phase_pkg.sv
// Shared definitions for the PLL dynamic phase-step controller:
// FSM state encoding, output count, position width and saturation limits.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP,
    S_GAP,
    S_LOAD,
    S_WAIT_LOCK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int NUM_PLL_OUT = 5;
  localparam int POS_W       = 10;
  localparam int POS_MAX     = 511;
  localparam int POS_MIN     = -511;

  // Signed position plus/minus an unsigned step count, clamped to +/-511.
  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] pos,
                                               input logic             dir,
                                               input logic [7:0]       steps);
    int sum;
    sum = int'($signed(pos)) + (dir ? int'(steps) : -int'(steps));
    if (sum > POS_MAX) sum = POS_MAX;
    else if (sum < POS_MIN) sum = POS_MIN;
    return POS_W'(sum);
  endfunction

endpackage

// File: rtl/pll_phase_step_ctrl_if.sv
// Request channel of the phase-step controller plus FSM state visibility.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_sel/req_dir/req_steps must be stable while
// req_valid is high, and req_ready is high only while the controller is idle.
interface pll_phase_step_ctrl_if;
  import pll_phase_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  state_t     state_dbg;

  modport master (
    output req_valid, req_sel, req_dir, req_steps,
    input  req_ready, state_dbg
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps,
    output req_ready, state_dbg
  );
endinterface

// File: rtl/pll_phase_step_ctrl_lock_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module lock_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Shift the asynchronous input through two flops; reset clears both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_phase_step_ctrl.sv
// Dynamic phase-shift initiator for the ADC clock PLL phase-adjust port.
// Emits spaced PHASE_STEP_N pulses, a LOAD_PHASE pulse, then waits for a
// stable re-lock. Optional feature macro: PLL_PHASE_ACCUM_EN (per-output
// signed position accumulators shown on phase_pos).
module pll_phase_step_ctrl
  import pll_phase_pkg::*;
#(
  parameter int STEP_GAP     = 8,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_phase_step_ctrl_if.slave req,
  input  logic                 pll_lock,
  output logic [2:0]           phase_sel,
  output logic                 phase_dir,
  output logic                 phase_step_n,
  output logic                 load_phase,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [POS_W-1:0]     phase_pos
);

  localparam int GAP_W = $clog2(STEP_GAP);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

  state_t           state, state_n;
  logic [2:0]       sel_q;
  logic             dir_q;
  logic [7:0]       steps_q;
  logic [7:0]       rem_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [STB_W-1:0] stable_cnt;
  logic [TO_W-1:0]  total_cnt;
  logic             lock_gated;
  logic             lock_s;

  // Lock only reaches the synchronizer while waiting for it, so lock
  // activity outside WAIT_LOCK never counts toward stability.
  assign lock_gated = pll_lock & (state == S_WAIT_LOCK);

  lock_sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock_gated),
    .q   (lock_s)
  );

  assign phase_sel     = sel_q;
  assign phase_dir     = dir_q;
  assign req.state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic and state-decoded (Moore) outputs.
  always_comb begin
    state_n       = state;
    req.req_ready = 1'b0;
    busy          = 1'b1;
    phase_step_n  = 1'b1;
    load_phase    = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    case (state)
      S_IDLE: begin
        req.req_ready = 1'b1;
        busy          = 1'b0;
        if (req.req_valid) state_n = S_SETUP;
      end
      S_SETUP: begin
        if (sel_q >= 3'(NUM_PLL_OUT)) state_n = S_ERR;
        else if (steps_q == 8'd0)     state_n = S_LOAD;
        else                          state_n = S_STEP;
      end
      S_STEP: begin
        phase_step_n = 1'b0;
        state_n      = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(STEP_GAP - 1))
          state_n = (rem_q != 8'd0) ? S_STEP : S_LOAD;
      end
      S_LOAD: begin
        load_phase = 1'b1;
        state_n    = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s && (stable_cnt == STB_W'(LOCK_STABLE - 1)))
          state_n = S_DONE;
        else if (total_cnt == TO_W'(LOCK_TIMEOUT - 1))
          state_n = S_ERR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request latch, remaining-step count, gap spacing and lock counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      dir_q      <= 1'b0;
      steps_q    <= '0;
      rem_q      <= '0;
      gap_cnt    <= '0;
      stable_cnt <= '0;
      total_cnt  <= '0;
    end else begin
      if (state == S_IDLE && req.req_valid) begin
        sel_q   <= req.req_sel;
        dir_q   <= req.req_dir;
        steps_q <= req.req_steps;
        rem_q   <= req.req_steps;
      end
      if (state == S_STEP) rem_q <= rem_q - 8'd1;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (state == S_WAIT_LOCK) begin
        total_cnt  <= total_cnt + TO_W'(1);
        stable_cnt <= lock_s ? stable_cnt + STB_W'(1) : '0;
      end else begin
        total_cnt  <= '0;
        stable_cnt <= '0;
      end
    end
  end

`ifdef PLL_PHASE_ACCUM_EN
  logic [POS_W-1:0] pos_q [NUM_PLL_OUT];
  logic [2:0]       last_sel;

  // Update the selected output's position as DONE is entered, so the new
  // value is visible during the DONE cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PLL_OUT; i++) pos_q[i] <= '0;
      last_sel <= '0;
    end else if (state == S_WAIT_LOCK && state_n == S_DONE) begin
      for (int i = 0; i < NUM_PLL_OUT; i++)
        if (sel_q == 3'(i)) pos_q[i] <= sat_add(pos_q[i], dir_q, steps_q);
      last_sel <= sel_q;
    end
  end

  // Present the position of the most recently completed output.
  always_comb begin
    phase_pos = '0;
    for (int i = 0; i < NUM_PLL_OUT; i++)
      if (last_sel == 3'(i)) phase_pos = pos_q[i];
  end
`else
  assign phase_pos = '0;
`endif

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Bench for pll_phase_step_ctrl: directed and randomized shift requests
// compared against a timeline model derived from the pulse-timing rules.
module tb_pll_phase_step_ctrl;
  import pll_phase_pkg::*;

  localparam int G    = 8;
  localparam int LS   = 16;
  localparam int LT   = 300;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic [2:0] phase_sel;
  logic       phase_dir, phase_step_n, load_phase, busy, done, err;
  logic [9:0] phase_pos;

  pll_phase_step_ctrl_if req_if ();

  pll_phase_step_ctrl #(.STEP_GAP(G), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req_if.slave),
    .pll_lock     (pll_lock),
    .phase_sel    (phase_sel),
    .phase_dir    (phase_dir),
    .phase_step_n (phase_step_n),
    .load_phase   (load_phase),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .phase_pos    (phase_pos)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard state.
  logic [15:0] exp_q[$];
  logic        pat [0:MAXC-1];
  int          pos_model [5];
  int          last_sel_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 511) return 511;
    if (v < -511) return -511;
    return v;
  endfunction

  function automatic logic [9:0] exp_pos();
`ifdef PLL_PHASE_ACCUM_EN
    return 10'(pos_model[last_sel_model]);
`else
    return 10'd0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_if.req_ready), 1);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_stepn"}, 32'(phase_step_n), 1);
    check({tag, "_load"},  32'(load_phase), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_sel"},   32'(phase_sel), 0);
    check({tag, "_dir"},   32'(phase_dir), 0);
    check({tag, "_pos"},   32'(phase_pos), 0);
    check({tag, "_state"}, 32'(req_if.state_dbg), 32'(S_IDLE));
  endtask

  // Driver + monitor for one request. mode: 0 lock high, 1 lock low,
  // 2 lock toggling every 10 cycles, 3 lock mostly high with random drops.
  task automatic run_req(input string name, input int sel, input int dir,
                         input int steps, input int mode);
    int L, term, cnt, n_load, load_at, n_done, n_err, n_step;
    bit is_done, valid_sel, held_ok, s;
    logic [15:0] obs_q[$];

    for (int i = 0; i < MAXC; i++) begin
      case (mode)
        0:       pat[i] = 1'b1;
        1:       pat[i] = 1'b0;
        2:       pat[i] = ((i / 10) % 2) == 0;
        default: pat[i] = ($urandom_range(0, 39) != 0);
      endcase
    end

    // Expected timeline, cycle 1 = first cycle after the accepting edge.
    exp_q.delete();
    valid_sel = (sel < 5);
    is_done = 1'b0;
    L = -1;
    if (!valid_sel) begin
      term = 2;
    end else begin
      for (int j = 0; j < steps; j++) exp_q.push_back(16'(2 + j * (G + 1)));
      L = 2 + steps * (G + 1);
      term = L + 1 + LT;
      cnt = 0;
      for (int c = L + 1; c <= L + LT; c++) begin
        s = (c - 2 >= L + 1) ? pat[c - 2] : 1'b0;
        cnt = s ? cnt + 1 : 0;
        if (cnt == LS) begin
          is_done = 1'b1;
          term = c + 1;
          break;
        end
      end
    end
    if (is_done) begin
      pos_model[sel] = clamp(pos_model[sel] + (dir != 0 ? steps : -steps));
      last_sel_model = sel;
    end

    @(negedge clk);
    check({name, "_ready_before"}, 32'(req_if.req_ready), 1);
    req_if.req_valid = 1'b1;
    req_if.req_sel   = 3'(sel);
    req_if.req_dir   = dir[0];
    req_if.req_steps = 8'(steps);
    pll_lock = pat[0];
    @(posedge clk);

    n_load = 0; load_at = -1; n_done = 0; n_err = 0; held_ok = 1'b1;
    for (int k = 1; k <= term + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_if.req_valid = 1'b0;
        check({name, "_ready_drop"}, 32'(req_if.req_ready), 0);
        check({name, "_busy"}, 32'(busy), 1);
      end
      if (!phase_step_n) obs_q.push_back(16'(k));
      if (load_phase) begin n_load++; load_at = k; end
      if (done) n_done++;
      if (err) n_err++;
      if (k <= term && (phase_sel !== 3'(sel) || phase_dir !== dir[0])) held_ok = 1'b0;
      if (k == term) begin
        check({name, "_done_at_term"}, 32'(done), 32'(is_done));
        check({name, "_err_at_term"}, 32'(err), 32'(!is_done));
        check({name, "_pos_term"}, 32'(phase_pos), 32'(exp_pos()));
      end
      if (k == term + 1) begin
        check({name, "_ready_back"}, 32'(req_if.req_ready), 1);
        check({name, "_idle_busy"}, 32'(busy), 0);
        check({name, "_pos_idle"}, 32'(phase_pos), 32'(exp_pos()));
      end
      pll_lock = pat[k];
    end

    check({name, "_sel_dir_held"}, 32'(held_ok), 1);
    n_step = obs_q.size();
    check({name, "_step_count"}, 32'(n_step), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({name, "_step_cycle"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    check({name, "_load_count"}, 32'(n_load), valid_sel ? 1 : 0);
    if (valid_sel) check({name, "_load_cycle"}, 32'(load_at), 32'(L));
    check({name, "_done_count"}, 32'(n_done), 32'(is_done));
    check({name, "_err_count"}, 32'(n_err), 32'(!is_done));
  endtask

  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_sel   = '0;
    req_if.req_dir   = 1'b0;
    req_if.req_steps = '0;
    for (int i = 0; i < 5; i++) pos_model[i] = 0;
    last_sel_model = 0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    // Lock activity while idle must not matter.
    repeat (4) begin @(negedge clk); pll_lock = ~pll_lock; end
    pll_lock = 1'b0;

    run_req("basic_s1_p3", 1, 1, 3, 0);
    run_req("zero_steps", 0, 1, 0, 0);
    run_req("bad_sel6", 6, 1, 4, 0);
    run_req("lock_low", 3, 0, 2, 1);
    run_req("lock_toggle", 4, 1, 1, 2);

    // Reset during the second gap: outputs return to reset values at once.
    @(negedge clk);
    req_if.req_valid = 1'b1;
    req_if.req_sel   = 3'd1;
    req_if.req_dir   = 1'b1;
    req_if.req_steps = 8'd3;
    pll_lock = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      req_if.req_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 5; i++) pos_model[i] = 0;
    last_sel_model = 0;
    @(negedge clk);
    rst = 1'b0;
    run_req("after_rst", 1, 1, 2, 0);

    run_req("sat_1", 2, 0, 255, 0);
    run_req("sat_2", 2, 0, 255, 0);
    run_req("sat_3", 2, 0, 255, 0);

    for (int r = 0; r < 8; r++) begin
      int m;
      m = $urandom_range(0, 3);
      run_req($sformatf("rand%0d", r), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 5), (m == 2) ? 2 : ((m == 1) ? 3 : m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
